vga_fb_arbiter: RTL and testbench
=================================

Name: vga_fb_arbiter

Overview:
- Schedules a single-port synchronous framebuffer RAM between two users:
  - the XGA scan-out path, which reads pixels using pixel_x, pixel_y and video_on from vga_controller;
  - a drawing/host writer, which uses a valid/ready handshake.
- Display reads always take priority. The writer gets every memory slot the display does not use.
- Provides double buffering. The front/back swap happens only at end of active frame, so there is no tearing.
- Sits between vga_controller and the framebuffer RAM, and drives the RGB pixel stream.

Parameters:
- H_ACTIVE, 1024, active pixels per line (must be even)
- V_ACTIVE, 768, active lines per frame
- BUF_AW, 19, word-address width of one buffer (H_ACTIVE/2*V_ACTIVE words)

Ports:
- clk  in  1  pixel clock, 65 MHz
- reset  in  1  synchronous, active-high
- pixel_x  in  11  current column from vga_controller
- pixel_y  in  10  current row from vga_controller
- video_on  in  1  active-video flag from vga_controller
- wr_valid  in  1  writer request
- wr_ready  out  1  writer slot available this cycle
- wr_addr  in  BUF_AW  word address within back buffer
- wr_data  in  24  two pixels; [11:0] = even pixel, [23:12] = odd pixel
- wr_be  in  2  pixel enables; bit0 = even pixel, bit1 = odd pixel
- swap_req  in  1  request a front/back swap at next frame end
- swap_done  out  1  one-cycle pulse when the swap takes effect
- front_sel  out  1  buffer currently displayed
- mem_en  out  1  RAM access strobe (registered)
- mem_we  out  2  per-pixel write enables (registered)
- mem_addr  out  BUF_AW+1  {buffer select, word address} (registered)
- mem_wdata  out  24  write data (registered)
- mem_rdata  in  24  RAM read data, valid 1 cycle after mem_en with mem_we=0
- pix_rgb  out  12  {R[11:8], G[7:4], B[3:0]}
- pix_valid  out  1  video_on delayed to align with pix_rgb

Behaviour:
- Reset: applies at any time, including mid-frame or mid-write, and is synchronous.
  - All outputs go to 0: mem_en, mem_we, mem_addr, mem_wdata, pix_rgb, pix_valid, swap_done, front_sel.
  - The swap-pending flag is cleared.
  - wr_ready is 0 while reset is high.
  - No in-flight write completes after reset.
- Display slot:
  - A display slot is claimed at cycle t when video_on=1 and pixel_x[0]=0.
  - At t+1: mem_en=1, mem_we=0, mem_addr={front_sel, pixel_y*(H_ACTIVE/2)+(pixel_x>>1)}.
- Writer slot:
  - wr_ready(t) = !reset && !(video_on && !pixel_x[0]). It is combinational and does not depend on wr_valid.
  - A handshake occurs when wr_valid && wr_ready at t.
  - At t+1: mem_en=1, mem_we=wr_be, mem_addr={~front_sel(t), wr_addr}, mem_wdata=wr_data.
  - If wr_be=0, the write is accepted but mem_en=0.
- Idle slot: with no handshake and no display slot, mem_en=0 and mem_we=0 at t+1.
- Pixel pipeline, fixed latency 3 cycles:
  - For even x sampled at t, pix_rgb at t+3 = mem_rdata[11:0] captured at t+2.
  - For x+1, pix_rgb at t+4 = the held mem_rdata[23:12].
  - pix_valid(t+3) = video_on(t).
  - pix_rgb = 0 whenever pix_valid = 0.
  - vga_controller delays hsync/vsync by 3 cycles to match.
- Swap FSM:
  - States: SHOW (no swap pending) and PEND (swap pending).
  - SHOW -> PEND on swap_req.
  - Frame end at t is defined as video_on && pixel_x==H_ACTIVE-1 && pixel_y==V_ACTIVE-1.
  - In PEND at frame end, or in SHOW with swap_req at frame end: front_sel toggles at t+1, swap_done=1 at t+1, state -> SHOW.
  - Further swap_req while in PEND is absorbed; only one swap occurs.
  - swap_req in the cycle after frame end waits for the following frame.
  - The last display read (pixel_x = H_ACTIVE-2) uses the old front_sel.
  - A write accepted at the frame-end cycle targets the old back buffer.
  - The first write accepted at t+1 targets the new back buffer.
- Boundaries:
  - During blanking, every cycle is a writer slot.
  - During active video, writers get odd-x cycles only, which is 50% bandwidth.
  - pixel_x/pixel_y values beyond active are ignored unless video_on=1.

Optional Feature:
- Macro: FBARB_STATS_EN.
- When defined:
  - Adds output stall_cnt[15:0].
  - Increments each cycle wr_valid && !wr_ready, saturating at 16'hFFFF.
  - Cleared by reset and in the cycle swap_done=1; a stall in that same cycle is not counted.
- When undefined: the port and the counter are absent; all other behaviour is identical.

Test Plan:
1. Reset mid-line: assert reset at pixel_x=100 with wr_valid=1 -> next cycle mem_en=0, front_sel=0, pix_rgb=0, wr_ready=0, and no write observed after release.
2. Display read: video_on=1, pixel_x=4, pixel_y=2, front_sel=0 -> mem_addr=0x00402 at t+1; with mem_rdata=0xABC123, pix_rgb=0x123 at t+3 and 0xABC at t+4.
3. Arbitration: wr_valid held through active video -> wr_ready=1 only on odd pixel_x; each write appears at t+1 with mem_addr[19]=1 and never overlaps a display read.
4. Blanking burst: 8 writes with wr_be=2'b01 during hblank -> 8 consecutive mem_en cycles with mem_we=01 and data/address matching each handshake in order.
5. Swap: swap_req pulsed twice mid-frame -> exactly one swap_done at the cycle after (1023,767); front_sel=1; the next frame reads from addresses with bit19=1.
6. FBARB_STATS_EN: 70000 stall cycles with no swap -> stall_cnt=0xFFFF; after swap_done -> 0.

Source files
------------

// File: rtl/vga_fb_arbiter.sv
// Framebuffer port arbiter: display reads on even active pixels, writer gets all other slots,
// double-buffered with tear-free swap at frame end. Define FBARB_STATS_EN to add the stall_cnt output.
module vga_fb_arbiter #(
  parameter int H_ACTIVE = 1024,
  parameter int V_ACTIVE = 768,
  parameter int BUF_AW   = 19
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [10:0]       pixel_x,
  input  logic [9:0]        pixel_y,
  input  logic              video_on,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [BUF_AW-1:0] wr_addr,
  input  logic [23:0]       wr_data,
  input  logic [1:0]        wr_be,
  input  logic              swap_req,
  output logic              swap_done,
  output logic              front_sel,
  output logic              mem_en,
  output logic [1:0]        mem_we,
  output logic [BUF_AW:0]   mem_addr,
  output logic [23:0]       mem_wdata,
  input  logic [23:0]       mem_rdata,
  output logic [11:0]       pix_rgb,
  output logic              pix_valid,
`ifdef FBARB_STATS_EN
  output logic [15:0]       stall_cnt,
`endif
  output logic              swap_state
);

  // Writer handshake: a transfer happens in any cycle where wr_valid && wr_ready.
  // wr_ready is combinational, never depends on wr_valid, and drops on display slots and reset.
  typedef enum logic {SHOW = 1'b0, PEND = 1'b1} state_t;

  state_t            state, state_nx;
  logic              disp_slot;
  logic              wr_hs;
  logic              frame_end;
  logic              do_swap;
  logic [BUF_AW-1:0] disp_addr;
  logic              v_d1, v_d2;
  logic              odd_d1, odd_d2;
  logic [11:0]       hold_hi;

  assign disp_slot = video_on && !pixel_x[0];
  assign wr_ready  = !reset && !disp_slot;
  assign wr_hs     = wr_valid && wr_ready;
  assign frame_end = video_on && (pixel_x == 11'(H_ACTIVE - 1)) && (pixel_y == 10'(V_ACTIVE - 1));
  assign disp_addr = BUF_AW'(pixel_y) * BUF_AW'(H_ACTIVE / 2) + BUF_AW'(pixel_x[10:1]);
  assign swap_state = state;

  // Memory request register
  always_ff @(posedge clk) begin
    if (reset) begin
      mem_en    <= 1'b0;
      mem_we    <= 2'b00;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else if (disp_slot) begin
      mem_en    <= 1'b1;
      mem_we    <= 2'b00;
      mem_addr  <= {front_sel, disp_addr};
    end else if (wr_hs) begin
      // A write with no pixel enables is consumed but never reaches the RAM.
      mem_en    <= |wr_be;
      mem_we    <= wr_be;
      mem_addr  <= {~front_sel, wr_addr};
      mem_wdata <= wr_data;
    end else begin
      mem_en    <= 1'b0;
      mem_we    <= 2'b00;
    end
  end

  // Pixel pipeline: the even pixel is taken straight from RAM, the odd one from hold_hi.
  always_ff @(posedge clk) begin
    if (reset) begin
      v_d1      <= 1'b0;
      v_d2      <= 1'b0;
      odd_d1    <= 1'b0;
      odd_d2    <= 1'b0;
      hold_hi   <= '0;
      pix_valid <= 1'b0;
      pix_rgb   <= '0;
    end else begin
      v_d1      <= video_on;
      v_d2      <= v_d1;
      odd_d1    <= pixel_x[0];
      odd_d2    <= odd_d1;
      pix_valid <= v_d2;
      if (!v_d2)
        pix_rgb <= '0;
      else if (odd_d2)
        pix_rgb <= hold_hi;
      else begin
        pix_rgb <= mem_rdata[11:0];
        hold_hi <= mem_rdata[23:12];
      end
    end
  end

  // Swap FSM: state register
  always_ff @(posedge clk) begin
    if (reset) state <= SHOW;
    else       state <= state_nx;
  end

  // Swap FSM: next state
  always_comb begin
    state_nx = state;
    if (do_swap)       state_nx = SHOW;
    else if (swap_req) state_nx = PEND;
  end

  // Swap FSM: outputs
  always_comb begin
    do_swap = 1'b0;
    if (frame_end && (state == PEND || swap_req)) do_swap = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      swap_done <= 1'b0;
      front_sel <= 1'b0;
    end else begin
      swap_done <= do_swap;
      if (do_swap) front_sel <= ~front_sel;
    end
  end

`ifdef FBARB_STATS_EN
  // Stall counter restarts each buffer swap and saturates instead of wrapping.
  always_ff @(posedge clk) begin
    if (reset || swap_done)
      stall_cnt <= '0;
    else if (wr_valid && !wr_ready && stall_cnt != 16'hFFFF)
      stall_cnt <= stall_cnt + 16'd1;
  end
`endif

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Directed bench for vga_fb_arbiter: vector table for single-cycle slots plus
// hand-written sequences for pixel pipeline, arbitration, bursts, reset and swap.
module tb_vga_fb_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [10:0] pixel_x;
  logic [9:0]  pixel_y;
  logic        video_on;
  logic        wr_valid;
  logic        wr_ready;
  logic [18:0] wr_addr;
  logic [23:0] wr_data;
  logic [1:0]  wr_be;
  logic        swap_req;
  logic        swap_done;
  logic        front_sel;
  logic        mem_en;
  logic [1:0]  mem_we;
  logic [19:0] mem_addr;
  logic [23:0] mem_wdata;
  logic [23:0] mem_rdata;
  logic [11:0] pix_rgb;
  logic        pix_valid;
  logic        swap_state;
`ifdef FBARB_STATS_EN
  logic [15:0] stall_cnt;
`endif

  int n_cmp = 0;
  int n_err = 0;
  logic [45:0] exp_q[$];

  typedef struct {
    string       nm;
    logic        vo;
    logic [10:0] x;
    logic [9:0]  y;
    logic        wv;
    logic [18:0] wa;
    logic [23:0] wd;
    logic [1:0]  be;
    logic        e_rdy;
    logic        e_en;
    logic [1:0]  e_we;
    logic [19:0] e_addr;
    logic [23:0] e_wd;
  } vec_t;

  vec_t vecs[9];

  vga_fb_arbiter dut (
    .clk(clk), .reset(reset), .pixel_x(pixel_x), .pixel_y(pixel_y), .video_on(video_on),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be),
    .swap_req(swap_req), .swap_done(swap_done), .front_sel(front_sel),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .pix_rgb(pix_rgb), .pix_valid(pix_valid),
`ifdef FBARB_STATS_EN
    .stall_cnt(stall_cnt),
`endif
    .swap_state(swap_state)
  );

  // Clock and watchdog
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive_idle();
    video_on = 1'b0; pixel_x = 11'd1100; pixel_y = 10'd800;
    wr_valid = 1'b0; wr_addr = '0; wr_data = '0; wr_be = 2'b00; swap_req = 1'b0;
  endtask

  task automatic drive(input logic vo, input logic [10:0] x, input logic [9:0] y, input logic wv,
                       input logic [18:0] wa, input logic [23:0] wd, input logic [1:0] be);
    video_on = vo; pixel_x = x; pixel_y = y;
    wr_valid = wv; wr_addr = wa; wr_data = wd; wr_be = be;
  endtask

  initial begin
    logic [18:0] ra;
    logic [23:0] rd;
    logic [45:0] exp_w;

    vecs[0] = '{"idle_blank",      1'b0, 11'd1100, 10'd800, 1'b0, 19'h0,     24'h0,      2'b00, 1'b1, 1'b0, 2'b00, 20'h0,     24'h0};
    vecs[1] = '{"disp_x4_y2",      1'b1, 11'd4,    10'd2,   1'b1, 19'h1,     24'h1,      2'b11, 1'b0, 1'b1, 2'b00, 20'h00402, 24'h0};
    vecs[2] = '{"wr_odd_x",        1'b1, 11'd5,    10'd2,   1'b1, 19'h12345, 24'h111222, 2'b11, 1'b1, 1'b1, 2'b11, 20'h92345, 24'h111222};
    vecs[3] = '{"wr_blank_maxadr", 1'b0, 11'd1030, 10'd2,   1'b1, 19'h7FFFF, 24'hFEDCBA, 2'b10, 1'b1, 1'b1, 2'b10, 20'hFFFFF, 24'hFEDCBA};
    vecs[4] = '{"wr_be0",          1'b0, 11'd1040, 10'd2,   1'b1, 19'h00033, 24'h777777, 2'b00, 1'b1, 1'b0, 2'b00, 20'h0,     24'h0};
    vecs[5] = '{"disp_last",       1'b1, 11'd1022, 10'd767, 1'b0, 19'h0,     24'h0,      2'b00, 1'b0, 1'b1, 2'b00, 20'h5FFFF, 24'h0};
    vecs[6] = '{"disp_origin",     1'b1, 11'd0,    10'd0,   1'b1, 19'h5,     24'h5,      2'b01, 1'b0, 1'b1, 2'b00, 20'h00000, 24'h0};
    vecs[7] = '{"blank_even_x",    1'b0, 11'd0,    10'd0,   1'b1, 19'h10,    24'h000ABC, 2'b01, 1'b1, 1'b1, 2'b01, 20'h80010, 24'h000ABC};
    vecs[8] = '{"active_odd_idle", 1'b1, 11'd1023, 10'd100, 1'b0, 19'h0,     24'h0,      2'b00, 1'b1, 1'b0, 2'b00, 20'h0,     24'h0};

    // Power-on reset state
    reset = 1'b1; mem_rdata = '0; drive_idle();
    #1;
    chk("rst_wr_ready", wr_ready, 0);
    step(); step();
    chk("rst_mem_en", mem_en, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_front_sel", front_sel, 0);
    chk("rst_pix", {pix_valid, pix_rgb}, 0);
    chk("rst_swap_done", swap_done, 0);
    reset = 1'b0;

    // Vector table
    for (int i = 0; i < 9; i++) begin
      drive(vecs[i].vo, vecs[i].x, vecs[i].y, vecs[i].wv, vecs[i].wa, vecs[i].wd, vecs[i].be);
      #1;
      chk({vecs[i].nm, "_ready"}, wr_ready, vecs[i].e_rdy);
      step();
      chk({vecs[i].nm, "_en"}, mem_en, vecs[i].e_en);
      chk({vecs[i].nm, "_we"}, mem_we, vecs[i].e_we);
      if (vecs[i].e_en) chk({vecs[i].nm, "_addr"}, mem_addr, vecs[i].e_addr);
      if (vecs[i].e_we != 2'b00) chk({vecs[i].nm, "_wdata"}, mem_wdata, vecs[i].e_wd);
    end

    // Pixel pipeline: even pixel at t+3, odd pixel from held upper half at t+4
    drive_idle(); mem_rdata = 24'h999999;
    drive(1'b1, 11'd4, 10'd2, 1'b0, 19'h0, 24'h0, 2'b00);
    step();
    chk("pipe_rd_addr", mem_addr, 20'h00402);
    pixel_x = 11'd5;
    step();
    video_on = 1'b0; pixel_x = 11'd1100; mem_rdata = 24'hABC123;
    step();
    chk("pipe_even", {pix_valid, pix_rgb}, {1'b1, 12'h123});
    mem_rdata = 24'h555555;
    step();
    chk("pipe_odd", {pix_valid, pix_rgb}, {1'b1, 12'hABC});
    step();
    chk("pipe_blank", {pix_valid, pix_rgb}, 13'h0);

    // Arbitration during active video with wr_valid held
    for (int x = 0; x < 16; x++) begin
      ra = 19'($urandom_range(0, 32'h7FFFF));
      rd = 24'($urandom_range(0, 32'hFFFFFF));
      drive(1'b1, 11'(x), 10'd10, 1'b1, ra, rd, 2'b11);
      #1;
      chk("arb_ready", wr_ready, x % 2);
      step();
      chk("arb_en", mem_en, 1);
      if (x % 2 == 1) chk("arb_wr", {mem_we, mem_addr, mem_wdata}, {2'b11, 1'b1, ra, rd});
      else            chk("arb_rd", {mem_we, mem_addr}, {2'b00, 1'b0, 19'(10 * 512 + x / 2)});
    end

    // Blanking burst: every cycle is a writer slot
    for (int i = 0; i < 8; i++) begin
      ra = 19'($urandom_range(0, 32'h7FFFF));
      rd = 24'($urandom_range(0, 32'hFFFFFF));
      drive(1'b0, 11'(1024 + i), 10'd50, 1'b1, ra, rd, 2'b01);
      exp_q.push_back({2'b01, 1'b1, ra, rd});
      #1;
      chk("burst_ready", wr_ready, 1);
      step();
      chk("burst_en", mem_en, 1);
      exp_w = exp_q.pop_front();
      chk("burst_req", {mem_we, mem_addr, mem_wdata}, exp_w);
    end

    // Swap: two requests mid-frame produce one swap at frame end
    drive_idle();
    drive(1'b1, 11'd10, 10'd300, 1'b0, 19'h0, 24'h0, 2'b00); swap_req = 1'b1;
    step();
    chk("swap_pend", swap_state, 1);
    pixel_x = 11'd20;
    step();
    pixel_x = 11'd21; swap_req = 1'b0;
    step();
    chk("swap_early", {swap_done, front_sel}, 2'b00);
    drive(1'b1, 11'd1022, 10'd767, 1'b0, 19'h0, 24'h0, 2'b00);
    step();
    chk("swap_last_read", mem_addr, 20'h5FFFF);
    drive(1'b1, 11'd1023, 10'd767, 1'b1, 19'h5, 24'h123456, 2'b11);
    #1;
    chk("swap_fe_ready", wr_ready, 1);
    step();
    chk("swap_done1", {swap_done, front_sel, swap_state}, 3'b110);
    chk("swap_fe_wr_addr", mem_addr, 20'h80005);
    drive(1'b0, 11'd1024, 10'd767, 1'b1, 19'h6, 24'h654321, 2'b11); swap_req = 1'b1;
    step();
    chk("swap_after_pulse", swap_done, 0);
    chk("swap_new_back", mem_addr, 20'h00006);
    chk("swap_late_req", swap_state, 1);
    swap_req = 1'b0;
    drive(1'b1, 11'd0, 10'd0, 1'b0, 19'h0, 24'h0, 2'b00);
    step();
    chk("swap_new_front_rd", mem_addr, 20'h80000);
    drive(1'b1, 11'd1023, 10'd767, 1'b0, 19'h0, 24'h0, 2'b00);
    step();
    chk("swap_done2", {swap_done, front_sel}, 2'b10);
    drive_idle();
    step();
    chk("swap_idle", swap_done, 0);
    drive(1'b1, 11'd1023, 10'd767, 1'b0, 19'h0, 24'h0, 2'b00); swap_req = 1'b1;
    step();
    chk("swap_direct", {swap_done, front_sel, swap_state}, 3'b110);
    swap_req = 1'b0;

    // Reset mid-line with an in-flight write and a pending swap
    drive(1'b1, 11'd99, 10'd5, 1'b1, 19'h9, 24'h0F0F0F, 2'b11); swap_req = 1'b1;
    step();
    chk("pre_rst_write", {mem_en, mem_addr}, {1'b1, 20'h00009});
    swap_req = 1'b0; reset = 1'b1;
    drive(1'b1, 11'd100, 10'd5, 1'b1, 19'hA, 24'h0F0F0F, 2'b11);
    #1;
    chk("mid_rst_ready", wr_ready, 0);
    step();
    chk("mid_rst_outs", {mem_en, mem_we, front_sel, pix_valid, pix_rgb, swap_done}, 0);
    chk("mid_rst_state", swap_state, 0);
    reset = 1'b0;
    drive(1'b1, 11'd101, 10'd5, 1'b0, 19'h0, 24'h0, 2'b00);
    step();
    chk("post_rst_no_wr", mem_en, 0);
    drive(1'b1, 11'd1023, 10'd767, 1'b0, 19'h0, 24'h0, 2'b00);
    step();
    chk("post_rst_no_swap", {swap_done, front_sel}, 2'b00);

`ifdef FBARB_STATS_EN
    // Stall counter saturates and clears on swap
    drive_idle();
    step();
    chk("stall_init", stall_cnt, 0);
    drive(1'b1, 11'd200, 10'd300, 1'b1, 19'h0, 24'h0, 2'b11);
    for (int i = 0; i < 70000; i++) step();
    chk("stall_sat", stall_cnt, 16'hFFFF);
    drive(1'b1, 11'd1023, 10'd767, 1'b1, 19'h0, 24'h0, 2'b11); swap_req = 1'b1;
    step();
    chk("stall_swap_done", swap_done, 1);
    swap_req = 1'b0;
    drive(1'b1, 11'd0, 10'd0, 1'b1, 19'h0, 24'h0, 2'b11);
    step();
    chk("stall_cleared", stall_cnt, 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
